// File: rtl/mem_slave_ctrl_if.sv
// Request/response bundle between a memory master and mem_slave_ctrl.
// The master drives the request fields and the slave returns ready and the
// read/error response.
interface mem_slave_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wstrb;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;
    logic                  err;

    modport master (
        output valid, wr_rd, addr, wdata, wstrb,
        input  ready, rdata, rvalid, err
    );

    modport slave (
        input  valid, wr_rd, addr, wdata, wstrb,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/mem_slave_ctrl.sv
// Single-port memory slave with byte-strobed writes and a fixed read latency.
// Optional feature macro MEM_RANGE_CHECK_EN: addresses >= DEPTH are flagged on
// err (writes dropped, reads return zero). Without it addresses wrap by
// low-bit truncation and DEPTH must be a power of 2.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; writes commit on the accepting edge
// RD_WAIT | read in flight, ready low; spans RD_LATENCY cycles
// RSP     | rvalid/rdata presented; a new request may be accepted here
module mem_slave_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         res,
    mem_slave_ctrl_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB    = WIDTH / 8;
    localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_slave_ctrl: WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("mem_slave_ctrl: RD_LATENCY must be 1..4");
    end
`ifndef MEM_RANGE_CHECK_EN
    if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
        $error("mem_slave_ctrl: DEPTH must be a power of 2 without range checking");
    end
`endif

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

    state_t            state, next_state;
    logic [1:0]        cnt, cnt_d;
    logic [IDX_W-1:0]  raddr;
    logic              rd_oor;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready_q, rvalid_q, err_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              ready_d, rvalid_d, err_d;
    logic [WIDTH-1:0]  rdata_d;

    logic              accept, acc_wr, acc_rd, addr_oor;
    logic [IDX_W-1:0]  idx;

    assign accept = bus.valid & ready_q;
    assign acc_wr = accept & bus.wr_rd;
    assign acc_rd = accept & ~bus.wr_rd;
    assign idx    = bus.addr[IDX_W-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign addr_oor = (32'(bus.addr) >= DEPTH);
`else
    assign addr_oor = 1'b0;
`endif

    assign bus.ready  = ready_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;

    // State, latency counter, latched read request and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= IDLE;
            cnt      <= '0;
            raddr    <= '0;
            rd_oor   <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_d;
            if (acc_rd) begin
                raddr  <= idx;
                rd_oor <= addr_oor;
            end
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state; the counter holds the remaining RD_WAIT cycles minus one
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        case (state)
            IDLE, RSP: begin
                next_state = IDLE;
                if (acc_rd) begin
                    next_state = RD_WAIT;
                    cnt_d      = LAT_M1;
                end
            end
            RD_WAIT: begin
                if (cnt == 2'd0) next_state = RSP;
                else             cnt_d = cnt - 2'd1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output values registered on the edge that enters the next state
    always_comb begin
        ready_d  = (next_state != RD_WAIT);
        rvalid_d = (next_state == RSP) && (state == RD_WAIT);
        err_d    = (acc_wr & addr_oor) | (rvalid_d & rd_oor);
        rdata_d  = rdata_q;
        if (rvalid_d) rdata_d = rd_oor ? '0 : mem[raddr];
    end

    // Byte-strobed write port; memory contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (acc_wr && !addr_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Bench for mem_slave_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level memory model.
module tb_mem_slave_ctrl;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int NB = W / 8;
    localparam int L  = 3;
`ifdef MEM_RANGE_CHECK_EN
    localparam int DEPTH = 200;
`else
    localparam int DEPTH = 128;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    mem_slave_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    mem_slave_ctrl #(
        .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(L)
    ) u_dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] ref_mem [DEPTH];
    int           cyc = 0;
    bit           rd_pending = 0;
    int           rd_edge = 0;
    bit           rd_err = 0;
    logic [W-1:0] rd_data = '0;
    bit           exp_ready = 0, exp_rvalid = 0, exp_err = 0;
    logic [W-1:0] exp_rdata = '0;
    bit           last_acc = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ref_oor(input logic [AW-1:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_idx(input logic [AW-1:0] a);
        return int'(a) % DEPTH;
    endfunction

    // One clock: apply the spec rules at the edge, then check at the negedge
    task automatic step();
        bit               acc, iw, wr_err;
        logic [AW-1:0]    ia;
        logic [W-1:0]     iwd;
        logic [NB-1:0]    istb;
        int               i;
        acc  = bus.valid && exp_ready && res;
        iw   = bus.wr_rd;
        ia   = bus.addr;
        iwd  = bus.wdata;
        istb = bus.wstrb;
        wr_err = 0;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (!res) begin
            rd_pending = 0;
            exp_ready = 0; exp_rvalid = 0; exp_err = 0; exp_rdata = '0;
        end else begin
            if (acc && iw) begin
                if (ref_oor(ia)) wr_err = 1;
                else begin
                    i = ref_idx(ia);
                    for (int b = 0; b < NB; b++)
                        if (istb[b]) ref_mem[i][8*b +: 8] = iwd[8*b +: 8];
                end
            end else if (acc) begin
                rd_pending = 1;
                rd_edge    = cyc;
                rd_err     = ref_oor(ia);
                rd_data    = rd_err ? '0 : ref_mem[ref_idx(ia)];
            end
            exp_ready  = !(rd_pending && (cyc - rd_edge) < L);
            exp_rvalid = rd_pending && (cyc - rd_edge) == L;
            if (exp_rvalid) begin
                exp_rdata  = rd_data;
                rd_pending = 0;
            end
            exp_err = wr_err || (exp_rvalid && rd_err);
        end
        @(negedge clk);
        check("ready",  W'(bus.ready),  W'(exp_ready));
        check("rvalid", W'(bus.rvalid), W'(exp_rvalid));
        check("err",    W'(bus.err),    W'(exp_err));
        check("rdata",  bus.rdata,      exp_rdata);
    endtask

    task automatic wait_accept(input string tag);
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) check(tag, 0, 1);
        bus.valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                            input logic [NB-1:0] s, output logic e);
        bus.valid = 1'b1; bus.wr_rd = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
        wait_accept("wr_accept_timeout");
        e = bus.err;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] d,
                           output logic e, output int low_cnt);
        bit got;
        got = 0;
        low_cnt = 0;
        bus.valid = 1'b1; bus.wr_rd = 1'b0; bus.addr = a;
        wait_accept("rd_accept_timeout");
        if (!bus.ready) low_cnt++;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (bus.rvalid) got = 1;
            else if (!bus.ready) low_cnt++;
        end
        if (!got) check("rd_rvalid_timeout", 0, 1);
        d = bus.rdata;
        e = bus.err;
    endtask

    logic [W-1:0] d, m0;
    logic         e;
    int           lc;
    int           acc_cyc [2];
    int           rv_cyc  [2];
    logic [W-1:0] rv_dat  [2];
    int           n_acc, n_rv;

    initial begin
        bus.valid = 1'b0; bus.wr_rd = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;

        // reset held for three cycles, then released
        res = 1'b0;
        repeat (3) step();
        res = 1'b1;
        step();
        check("ready_after_reset", W'(bus.ready), 1);

        // fill the whole memory so every later read has a known reference
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), $urandom, 4'hF, e);

        do_write(8'h10, 32'hDEADBEEF, 4'hF, e);
        do_read(8'h10, d, e, lc);
        check("full_write_read", d, 32'hDEADBEEF);
        check("read_ready_low_edges", lc, L);

        do_write(8'h10, 32'h11223344, 4'b0101, e);
        do_read(8'h10, d, e, lc);
        check("partial_write_read", d, 32'hDE22BE44);

        do_write(8'h10, 32'h0BADF00D, 4'h0, e);
        do_read(8'h10, d, e, lc);
        check("zero_strobe_noop", d, 32'hDE22BE44);

        // back-to-back reads with valid held high
        do_write(8'h00, 32'd1, 4'hF, e);
        do_write(8'h01, 32'd2, 4'hF, e);
        n_acc = 0; n_rv = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; rv_cyc[0] = 0; rv_cyc[1] = 0;
        rv_dat[0] = '0; rv_dat[1] = '0;
        bus.valid = 1'b1; bus.wr_rd = 1'b0; bus.addr = 8'h00;
        for (int k = 0; k < 30 && n_rv < 2; k++) begin
            step();
            if (last_acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                bus.addr = 8'h01;
                if (n_acc == 2) bus.valid = 1'b0;
            end
            if (bus.rvalid) begin
                rv_cyc[n_rv] = cyc;
                rv_dat[n_rv] = bus.rdata;
                n_rv++;
            end
        end
        bus.valid = 1'b0;
        check("b2b_rvalid_count", n_rv, 2);
        check("b2b_data0", rv_dat[0], 32'd1);
        check("b2b_data1", rv_dat[1], 32'd2);
        check("b2b_rvalid_gap", rv_cyc[1] - rv_cyc[0], L + 1);
        check("b2b_accept_leaving_rsp", acc_cyc[1], rv_cyc[0] + 1);

`ifdef MEM_RANGE_CHECK_EN
        m0 = ref_mem[0];
        do_write(8'd200, 32'hFFFF0000, 4'hF, e);
        check("oor_write_err", W'(e), 1);
        do_read(8'd0, d, e, lc);
        check("oor_write_mem0_kept", d, m0);
        check("inrange_read_err", W'(e), 0);
        do_read(8'd250, d, e, lc);
        check("oor_read_rdata", d, 0);
        check("oor_read_err", W'(e), 1);
`else
        do_write(8'd2, 32'hCAFE0002, 4'hF, e);
        check("wrap_write_err", W'(e), 0);
        do_read(8'd130, d, e, lc);
        check("wrap_read", d, 32'hCAFE0002);
        check("wrap_read_err", W'(e), 0);
`endif

        // reset asserted two edges into a read
        bus.valid = 1'b1; bus.wr_rd = 1'b0; bus.addr = 8'h10;
        wait_accept("rst_rd_accept_timeout");
        step();
        step();
        res = 1'b0;
        #1;
        check("rst_mid_ready",  W'(bus.ready), 0);
        check("rst_mid_rvalid", W'(bus.rvalid), 0);
        check("rst_mid_rdata",  bus.rdata, 0);
        rd_pending = 0;
        exp_ready = 0; exp_rvalid = 0; exp_err = 0; exp_rdata = '0;
        repeat (2) step();
        res = 1'b1;
        step();
        check("rst_release_ready", W'(bus.ready), 1);
        do_read(8'h10, d, e, lc);
        check("rst_mem_intact", d, 32'hDE22BE44);

        // random traffic, master free to change requests while not ready
        for (int k = 0; k < 1500; k++) begin
            bus.valid = ($urandom_range(0, 9) < 6);
            bus.wr_rd = $urandom_range(0, 1);
            bus.addr  = AW'($urandom_range(0, 255));
            bus.wdata = $urandom;
            bus.wstrb = NB'($urandom);
            step();
        end
        bus.valid = 1'b0;
        repeat (L + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
